vedic_mult_seq: RTL

//  Parametrised, sequential successor to the combinational Vedic multiplier tree.
//  One CHUNKxCHUNK Vedic core is time-shared over all (WIDTH/CHUNK)^2 partial products.

---
 rtl/vedic_pkg.sv | 38 +++
 rtl/vedic_mult_seq_if.sv | 28 ++
 rtl/vedic_chunk_mult.sv | 32 +++
 rtl/vedic_mult_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier.
//   state_e     : controller states (IDLE, MUL, DONE)
//   calc_k      : number of CHUNK-wide slices per operand
//   calc_n      : number of partial products (K*K)
//   calc_idx_w  : width of the partial-product index counter (at least 1)
//   abs_w       : magnitude of a w-bit value, two's-complement when sgn=1
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_k(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_n(input int width, input int chunk);
    return (width / chunk) * (width / chunk);
  endfunction

  function automatic int calc_idx_w(input int width, input int chunk);
    int n;
    n = (width / chunk) * (width / chunk);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The operand arrives zero-extended in v; only the low w bits are meaningful.
  // -2^(w-1) maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [63:0] abs_w(input logic [63:0] v, input int w, input logic sgn);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sgn && v[6'(w - 1)]) return (~v + 64'd1) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/vedic_mult_seq_if.sv
// Handshake bundle between operand source / result sink and the multiplier.
//   in_valid, in_ready, in_a, in_b, in_signed : operand channel
//   out_valid, out_ready, out_result         : result channel
//   busy                                      : accumulation in progress
// master = source/sink side, slave = multiplier side.
interface vedic_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/vedic_chunk_mult.sv
// Combinational WxW unsigned Vedic multiplier core.
//   a, b : W-bit unsigned operands (W a power of two, >= 2)
//   p    : 2W-bit product
// Built recursively: a 2x2 cell at the leaves, otherwise four half-width
// cores whose products are combined with shifted adds.
module vedic_chunk_mult #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W == 2) begin : g_leaf
    logic c1;
    // Vertical-and-crosswise on 2 bits: middle column carries into bit 2.
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : g_tree
    localparam int H = W / 2;
    logic [W-1:0] ll, lh, hl, hh;

    vedic_chunk_mult #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_chunk_mult #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
    vedic_chunk_mult #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_chunk_mult #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));

    assign p = (2*W)'(ll) + ((2*W)'(lh) << H) + ((2*W)'(hl) << H) + ((2*W)'(hh) << W);
  end
endmodule

// File: rtl/vedic_mult_seq.sv
// Sequential Vedic multiplier: one CHUNKxCHUNK core is time-shared over all
// (WIDTH/CHUNK)^2 partial products, shift-accumulated one per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of vedic_mult_seq_if (operand/result handshakes, busy)
// Signed mode multiplies magnitudes and negates the final sum when the
// operand signs differ. Result appears exactly N edges after acceptance.
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  vedic_mult_seq_if.slave         bus
);
  localparam int K     = calc_k(WIDTH, CHUNK);
  localparam int N     = calc_n(WIDTH, CHUNK);
  localparam int IDX_W = calc_idx_w(WIDTH, CHUNK);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, res_q, res_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [31:0]          ia, ib;
  logic [CHUNK-1:0]     a_chunk, b_chunk;
  logic [2*CHUNK-1:0]   core_p;
  logic [2*WIDTH-1:0]   term, acc_next;

  vedic_chunk_mult #(.W(CHUNK)) u_core (.a(a_chunk), .b(b_chunk), .p(core_p));

  // Chunk select and shift-accumulate: idx walks a's slices fastest.
  always_comb begin
    ia       = 32'(idx_q) % 32'(K);
    ib       = 32'(idx_q) / 32'(K);
    a_chunk  = CHUNK'(a_q >> (ia * CHUNK));
    b_chunk  = CHUNK'(b_q >> (ib * CHUNK));
    term     = (2*WIDTH)'(core_p) << ((ia + ib) * CHUNK);
    acc_next = acc_q + term;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    res_d       = res_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = WIDTH'(abs_w(64'(bus.in_a), WIDTH, bus.in_signed));
          b_d        = WIDTH'(abs_w(64'(bus.in_b), WIDTH, bus.in_signed));
          neg_d      = bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
          acc_d      = '0;
          idx_d      = '0;
          state_d    = MUL;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      MUL: begin
        acc_d = acc_next;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          res_d       = neg_q ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.busy       = busy_q;

endmodule
